// File: rtl/park_spot_alloc.sv
// park_spot_alloc: parking spot allocator for two areas (A, B) of three spots each.
// A user picks an area on key[11:10]; the block grants the lowest free spot,
// shows its code, and holds that display until a confirm (rising edge of bt[3]).
// The checker frees a spot by pulsing release_valid with the spot code.
// Optional feature: define PARK_SHOW_TIMEOUT_EN to return SHOW/FULL to SELECT
// after SHOW_CYCLES cycles without a confirm edge.
module park_spot_alloc #(
    parameter int SHOW_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  view,
    input  logic [11:0] key,
    input  logic [4:0]  bt,
    input  logic        release_valid,
    input  logic [2:0]  release_num,
    output logic [5:0]  a_pos,
    output logic [5:0]  b_pos,
    output logic        alloc_valid,
    output logic [2:0]  alloc_num,
    output logic [11:0] disp_code,
    output logic        area_full
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ALLOC  = 3'd2,
        S_SHOW   = 3'd3,
        S_FULL   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_area;        // latched area: 0 = A, 1 = B
    logic        r_bt3;         // previous bt[3] for edge detection
    logic [5:0]  r_a_pos;
    logic [5:0]  r_b_pos;
    logic        r_alloc_valid;
    logic [2:0]  r_alloc_num;
    logic [11:0] r_disp;

    logic        w_view_on;
    logic        w_confirm;
    logic        w_area_req;
    logic [5:0]  w_sel_pos;
    logic        w_found;
    logic [1:0]  w_idx;
    logic        w_grant;
    logic        w_timeout;
    logic [5:0]  w_a_next;
    logic [5:0]  w_b_next;
    logic [2:0]  w_show_num;
    logic [11:0] w_disp_next;
    logic        w_unused;

    // Clear the occupancy field belonging to spot idx (1..3); idx 0 is a no-op.
    function automatic logic [5:0] f_clr(input logic [5:0] pos, input logic [1:0] idx);
        logic [5:0] p;
        p = pos;
        case (idx)
            2'd1:    p[1:0] = 2'b00;
            2'd2:    p[3:2] = 2'b00;
            2'd3:    p[5:4] = 2'b00;
            default: p = pos;
        endcase
        return p;
    endfunction

    // Mark spot idx occupied; an occupied field carries its own spot number.
    function automatic logic [5:0] f_set(input logic [5:0] pos, input logic [1:0] idx);
        logic [5:0] p;
        p = pos;
        case (idx)
            2'd1:    p[1:0] = 2'd1;
            2'd2:    p[3:2] = 2'd2;
            2'd3:    p[5:4] = 2'd3;
            default: p = pos;
        endcase
        return p;
    endfunction

    // Two-digit display pattern for a spot index.
    function automatic logic [7:0] f_digits(input logic [1:0] idx);
        logic [7:0] d;
        case (idx)
            2'd1:    d = 8'h02;
            2'd2:    d = 8'h20;
            2'd3:    d = 8'h22;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    assign w_view_on  = (view == 3'd2);
    assign w_confirm  = bt[3] & ~r_bt3;
    assign w_area_req = (key[11:10] == 2'b01) || (key[11:10] == 2'b10);
    assign w_sel_pos  = r_area ? r_b_pos : r_a_pos;
    assign w_grant    = (r_state == S_ALLOC) && w_found;
    assign w_unused   = ^{key[9:0], bt[4], bt[2:0]};

    // Lowest free spot in the latched area, searched on pre-release occupancy.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 2'd0;
        if (w_sel_pos[1:0] == 2'b00) begin
            w_found = 1'b1;
            w_idx   = 2'd1;
        end else if (w_sel_pos[3:2] == 2'b00) begin
            w_found = 1'b1;
            w_idx   = 2'd2;
        end else if (w_sel_pos[5:4] == 2'b00) begin
            w_found = 1'b1;
            w_idx   = 2'd3;
        end
    end

`ifdef PARK_SHOW_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    assign w_timeout = ((r_state == S_SHOW) || (r_state == S_FULL)) &&
                       (r_to_cnt == 32'(SHOW_CYCLES - 1));

    // Dwell counter: zero outside SHOW/FULL, so it starts fresh on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= 32'd0;
        end else if ((r_state == S_SHOW) || (r_state == S_FULL)) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end else begin
            r_to_cnt <= 32'd0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic; leaving the UI page forces IDLE from any state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_view_on) w_next = S_SELECT;
            S_SELECT: if (w_area_req) w_next = S_ALLOC;
            S_ALLOC:  w_next = w_found ? S_SHOW : S_FULL;
            S_SHOW,
            S_FULL:   if (w_confirm || w_timeout) w_next = S_SELECT;
            default:  w_next = S_IDLE;
        endcase
        if (!w_view_on) w_next = S_IDLE;
    end

    // Occupancy update: release clears first, then a grant sets its field.
    always_comb begin
        w_a_next = r_a_pos;
        w_b_next = r_b_pos;
        if (release_valid) begin
            if (release_num[2]) w_b_next = f_clr(w_b_next, release_num[1:0]);
            else                w_a_next = f_clr(w_a_next, release_num[1:0]);
        end
        if (w_grant) begin
            if (r_area) w_b_next = f_set(w_b_next, w_idx);
            else        w_a_next = f_set(w_a_next, w_idx);
        end
    end

    // Display shows the spot just granted or the one already on screen.
    always_comb begin
        w_show_num  = w_grant ? {r_area, w_idx} : r_alloc_num;
        w_disp_next = 12'h000;
        if (w_next == S_SHOW)
            w_disp_next = {(w_show_num[2] ? 4'hb : 4'ha), f_digits(w_show_num[1:0])};
    end

    // Control state: FSM, latched area and confirm history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_area  <= 1'b0;
            r_bt3   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_bt3   <= bt[3];
            if ((r_state == S_SELECT) && w_view_on && w_area_req)
                r_area <= key[11];
        end
    end

    // Occupancy maps and registered grant/display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_pos       <= 6'd0;
            r_b_pos       <= 6'd0;
            r_alloc_valid <= 1'b0;
            r_alloc_num   <= 3'd0;
            r_disp        <= 12'h000;
        end else begin
            r_a_pos       <= w_a_next;
            r_b_pos       <= w_b_next;
            r_alloc_valid <= w_grant;
            r_disp        <= w_disp_next;
            if (w_grant)
                r_alloc_num <= {r_area, w_idx};
        end
    end

    assign a_pos       = r_a_pos;
    assign b_pos       = r_b_pos;
    assign alloc_valid = r_alloc_valid;
    assign alloc_num   = r_alloc_num;
    assign disp_code   = r_disp;
    assign area_full   = (r_state == S_FULL);

endmodule

// File: tb/tb_park_spot_alloc.sv
// Testbench for park_spot_alloc: directed scenarios followed by random traffic,
// predicted by a spot-table model and checked through scoreboard queues.
module tb_park_spot_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  view;
    logic [11:0] key;
    logic [4:0]  bt;
    logic        release_valid;
    logic [2:0]  release_num;
    logic [5:0]  a_pos;
    logic [5:0]  b_pos;
    logic        alloc_valid;
    logic [2:0]  alloc_num;
    logic [11:0] disp_code;
    logic        area_full;

    always #5 clk = ~clk;

    park_spot_alloc dut (
        .clk           (clk),
        .rst           (rst),
        .view          (view),
        .key           (key),
        .bt            (bt),
        .release_valid (release_valid),
        .release_num   (release_num),
        .a_pos         (a_pos),
        .b_pos         (b_pos),
        .alloc_valid   (alloc_valid),
        .alloc_num     (alloc_num),
        .disp_code     (disp_code),
        .area_full     (area_full)
    );

    typedef struct packed {
        logic [5:0]  a;
        logic [5:0]  b;
        logic        av;
        logic [2:0]  an;
        logic [11:0] disp;
        logic        full;
    } status_t;

    typedef struct packed {
        logic [2:0]  num;
        logic [11:0] disp;
    } grant_t;

    status_t sq[$];
    grant_t  gq[$];
    int n_cmp = 0;
    int n_bad = 0;

    localparam int M_IDLE = 0, M_SELECT = 1, M_ALLOC = 2, M_SHOW = 3, M_FULL = 4;

    // Reference model: a table of spots and the user-visible page.
    bit         m_occ [0:1][1:3];
    int         m_phase;
    int         m_area;
    bit         m_prev_bt;
    logic [2:0] m_last;
    bit         m_grant;

    function automatic logic [5:0] pack_area(input int ar);
        logic [5:0] p;
        p = 6'd0;
        for (int k = 0; k < 3; k++)
            if (m_occ[ar][k+1]) p[2*k +: 2] = 2'(k + 1);
        return p;
    endfunction

    function automatic logic [11:0] show_code(input logic [2:0] num);
        logic [7:0] d;
        case (num[1:0])
            2'd1:    d = 8'h02;
            2'd2:    d = 8'h20;
            2'd3:    d = 8'h22;
            default: d = 8'h00;
        endcase
        return {(num[2] ? 4'hb : 4'ha), d};
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++)
            for (int i = 1; i <= 3; i++) m_occ[a][i] = 1'b0;
        m_phase   = M_IDLE;
        m_area    = 0;
        m_prev_bt = 1'b0;
        m_last    = 3'd0;
        m_grant   = 1'b0;
    endtask

    task automatic model_step();
        bit   conf;
        int   nph;
        int   gidx;
        logic [11:0] disp;
        conf      = bt[3] && !m_prev_bt;
        m_prev_bt = bt[3];
        nph       = m_phase;
        gidx      = 0;
        m_grant   = 1'b0;
        case (m_phase)
            M_IDLE:   if (view == 3'd2) nph = M_SELECT;
            M_SELECT: if (view == 3'd2) begin
                if (key[11:10] == 2'b01) begin m_area = 0; nph = M_ALLOC; end
                else if (key[11:10] == 2'b10) begin m_area = 1; nph = M_ALLOC; end
            end
            M_ALLOC: begin
                for (int i = 1; i <= 3; i++)
                    if (gidx == 0 && !m_occ[m_area][i]) gidx = i;
                nph = (gidx != 0) ? M_SHOW : M_FULL;
            end
            M_SHOW, M_FULL: if (conf) nph = M_SELECT;
            default: nph = M_IDLE;
        endcase
        if (view != 3'd2) nph = M_IDLE;
        if (release_valid && release_num[1:0] != 2'd0)
            m_occ[int'(release_num[2])][int'(release_num[1:0])] = 1'b0;
        if (gidx != 0) begin
            m_occ[m_area][gidx] = 1'b1;
            m_grant = 1'b1;
            m_last  = {1'(m_area), 2'(gidx)};
        end
        m_phase = nph;
        disp = (m_phase == M_SHOW) ? show_code(m_last) : 12'h000;
        if (m_grant) gq.push_back('{num: m_last, disp: disp});
    endtask

    // One clock edge: let the model follow the edge just taken, then queue expectations.
    task automatic tick();
        status_t s;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else      model_step();
        s.a    = pack_area(0);
        s.b    = pack_area(1);
        s.av   = m_grant;
        s.an   = m_last;
        s.disp = (m_phase == M_SHOW) ? show_code(m_last) : 12'h000;
        s.full = (m_phase == M_FULL);
        sq.push_back(s);
    endtask

    task automatic set_in(input logic [2:0] v, input logic [11:0] k, input logic [4:0] b,
                          input logic rv, input logic [2:0] rn);
        view          = v;
        key           = k;
        bt            = b;
        release_valid = rv;
        release_num   = rn;
    endtask

    task automatic drive(input logic [2:0] v, input logic [11:0] k, input logic [4:0] b,
                         input logic rv, input logic [2:0] rn);
        tick();
        set_in(v, k, b, rv, rn);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations on the falling edge, away from the active edge.
    initial begin
        status_t e;
        grant_t  g;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("a_pos",       32'(a_pos),       32'(e.a));
                chk("b_pos",       32'(b_pos),       32'(e.b));
                chk("alloc_valid", 32'(alloc_valid), 32'(e.av));
                chk("alloc_num",   32'(alloc_num),   32'(e.an));
                chk("disp_code",   32'(disp_code),   32'(e.disp));
                chk("area_full",   32'(area_full),   32'(e.full));
            end
            if (alloc_valid) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 32'(alloc_num), 32'hffff_ffff);
                end else begin
                    g = gq.pop_front();
                    chk("grant_num",  32'(alloc_num), 32'(g.num));
                    chk("grant_disp", 32'(disp_code), 32'(g.disp));
                end
            end
        end
    end

    localparam logic [11:0] K_A = 12'h400;
    localparam logic [11:0] K_B = 12'h800;

    task automatic confirm_and_run(input logic [11:0] k, input int n);
        drive(3'd2, k, 5'h08, 1'b0, 3'd0);
        repeat (n) drive(3'd2, k, 5'h00, 1'b0, 3'd0);
    endtask

    initial begin
        rst = 1'b0;
        set_in(3'd0, 12'h000, 5'h00, 1'b0, 3'd0);
        model_reset();
        repeat (3) tick();
        rst = 1'b1;

        // First A grant after selecting area A
        repeat (5) drive(3'd2, K_A, 5'h00, 1'b0, 3'd0);
        // Two more A grants, then a request into a full area
        confirm_and_run(K_A, 4);
        confirm_and_run(K_A, 4);
        confirm_and_run(K_A, 4);
        // Release spot A2 while FULL, then re-request A
        drive(3'd2, K_A, 5'h00, 1'b1, 3'b010);
        drive(3'd2, K_A, 5'h00, 1'b0, 3'd0);
        confirm_and_run(K_A, 4);
        // First B grant
        confirm_and_run(K_B, 4);
        // Release B1 exactly on the ALLOC cycle of the next B request
        drive(3'd2, K_B, 5'h08, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_phase == M_ALLOC) set_in(3'd2, K_B, 5'h00, 1'b1, 3'b101);
            else                    set_in(3'd2, K_B, 5'h00, 1'b0, 3'd0);
        end
        // Confirm held high for ten cycles, area select idle
        repeat (10) drive(3'd2, 12'h000, 5'h08, 1'b0, 3'd0);
        drive(3'd2, 12'h000, 5'h00, 1'b0, 3'd0);
        // Leave the page from SELECT
        repeat (3) drive(3'd3, K_B, 5'h00, 1'b0, 3'd0);

        // Reset asserted while an allocation is pending
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_phase == M_ALLOC) break;
            set_in(3'd2, K_A, 5'h00, 1'b0, 3'd0);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_in(3'd2, 12'h000, 5'h00, 1'b0, 3'd0);

        // Random traffic
        for (int c = 0; c < 2500; c++) begin
            logic [2:0]  v;
            logic [11:0] k;
            logic [4:0]  b;
            v = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
            k = {2'($urandom_range(0, 3)), 10'($urandom)};
            b = 5'($urandom) & 5'h17;
            if ($urandom_range(0, 3) == 0) b[3] = 1'b1;
            drive(v, k, b, ($urandom_range(0, 5) == 0), 3'($urandom));
        end

        drive(3'd2, 12'h000, 5'h00, 1'b0, 3'd0);
        repeat (3) drive(3'd2, 12'h000, 5'h00, 1'b0, 3'd0);
        @(negedge clk);
        #1;
        chk("status_drained", 32'(sq.size()), 32'd0);
        chk("grants_drained", 32'(gq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/park_spot_alloc.md
PARK_SPOT_ALLOC -- requirements
Module: park_spot_alloc

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 100_000_000, meaning the number of cycles SHOW is held before auto-return (used only with PARK_SHOW_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port view, input, 3, UI page select; the block is active only when view==2.
REQ-005 SHALL have port key, input, 12, switches; key[11:10] is area select (01=A, 10=B); key[9:0] is unused.
REQ-006 SHALL have port bt, input, 5, buttons; bt[3] is confirm.
REQ-007 SHALL have ports release_valid (input, 1) and release_num (input, 3): one-cycle exit pulse from the checker, and the spot code to free.
REQ-008 SHALL have ports a_pos and b_pos, output, 6 each: occupancy; field k (bits 2k+1:2k) equals k+1 when spot k+1 is occupied, 00 when free.
REQ-009 SHALL have ports alloc_valid (output, 1) and alloc_num (output, 3): alloc_valid is a one-cycle grant pulse; alloc_num is {area, idx[1:0]} with A=0, B=1, idx 1..3.
REQ-010 SHALL have port disp_code, output, 12, display code: area nibble (A=4'ha, B=4'hb), then the BCD digit pair.
REQ-011 SHALL have port area_full, output, 1: high while in state FULL.

Function
REQ-012 Confirm SHALL be the rising edge of bt[3] (previous value registered); a level held high SHALL count once.
REQ-013 States SHALL be IDLE, SELECT, ALLOC, SHOW and FULL.
REQ-014 IDLE SHALL go to SELECT when view==2.
REQ-015 SELECT SHALL latch the area when key[11:10] is 01 or 10 and go to ALLOC on the next cycle; values 00 and 11 SHALL be ignored.
REQ-016 ALLOC SHALL take exactly one cycle: choose the lowest free idx in the latched area.
REQ-017 If ALLOC finds a free spot, it SHALL write field idx to the value idx, pulse alloc_valid, drive alloc_num, and enter SHOW on the same edge.
REQ-018 If ALLOC finds no free spot, it SHALL leave occupancy unchanged and enter FULL.
REQ-019 The spot-to-digit mapping SHALL be idx1 -> 8'h02, idx2 -> 8'h20, idx3 -> 8'h22; disp_code SHALL be valid in SHOW and 12'h000 otherwise.
REQ-020 SHOW and FULL SHALL hold until a confirm edge, then go to SELECT.
REQ-021 Whenever view!=2, the block SHALL go to IDLE next cycle from any state; no allocation SHALL start; if ALLOC was pending, its write still completes that cycle.
REQ-022 A release with release_num in {1,2,3,5,6,7} SHALL clear the matching field to 00 on that edge, in any state.
REQ-023 A release of an already-free spot, or with release_num of 0 or 4, SHALL be ignored.
REQ-024 When a release and an ALLOC write occur in the same cycle, both SHALL apply; ALLOC SHALL search the pre-release occupancy, so the freed spot is not granted that cycle.
REQ-025 alloc_num SHALL hold its last grant until the next grant.

Reset
REQ-026 While rst==0: state=IDLE; a_pos=b_pos=0; alloc_valid=0; alloc_num=0; disp_code=0; area_full=0; confirm history=0.
REQ-027 Reset asserted mid-allocation SHALL discard the grant and any occupancy change.

Configuration
REQ-028 With PARK_SHOW_TIMEOUT_EN defined, a counter SHALL clear on entry to SHOW or FULL and return the FSM to SELECT after SHOW_CYCLES cycles with no confirm edge; a confirm edge still exits early.
REQ-029 Without PARK_SHOW_TIMEOUT_EN, no counter SHALL exist and SHOW/FULL SHALL exit only by confirm or a view change.

Verification
REQ-030 After reset, set view=2, key[11:10]=01 -> two cycles later alloc_valid pulses, alloc_num=3'b001, a_pos=6'b000001, disp_code=12'ha02.
REQ-031 Perform three A grants, then one more A request -> area_full=1, a_pos=6'b111001 unchanged, no alloc_valid.
REQ-032 With a_pos=6'b111001 (full), pulse release_valid with release_num=3'b010 -> a_pos=6'b110001; the next A request grants 3'b010 with disp_code=12'ha20.
REQ-033 Release 3'b101 in the same cycle B is in ALLOC with b_pos=6'b000001 -> b_pos=6'b001000, grant 3'b110.
REQ-034 Hold bt[3] high for 10 cycles in SHOW -> exactly one exit to SELECT; switch view to 3 in SELECT -> IDLE next cycle with no grant.
REQ-035 With PARK_SHOW_TIMEOUT_EN and SHOW_CYCLES=8, enter SHOW with no confirm -> back in SELECT after 8 cycles, disp_code=0.
